// File: rtl/status_message_encoder.sv
// Turns navigation events into ASCII status frames "#T-NN-S#\n" for a byte-wide UART
// transmitter, buffering up to four events. Define STATUS_CHECKSUM_EN to append a hex XOR checksum.
module status_message_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_valid,
    output logic       evt_ready,
    input  logic [1:0] evt_type,
    input  logic [4:0] evt_node,
    input  logic [1:0] evt_subunit,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] frame_count
);

`ifdef STATUS_CHECKSUM_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 9;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t      state_q, state_d;
    logic [8:0]  fifo_mem_q [4];
    logic [8:0]  fifo_mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [8:0]  frame_q, frame_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        push;
    logic        pop;

`ifdef STATUS_CHECKSUM_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0000, n}) : (8'h37 + {4'b0000, n});
    endfunction
`endif

    function automatic logic [7:0] type_char(input logic [1:0] t);
        case (t)
            2'd0:    return 8'h4E;
            2'd1:    return 8'h50;
            2'd2:    return 8'h44;
            default: return 8'h45;
        endcase
    endfunction

    // Frame entry layout is {type[1:0], node[4:0], subunit[1:0]}.
    function automatic logic [7:0] frame_byte(input logic [8:0] f, input logic [3:0] idx);
        logic [4:0] node;
        logic [4:0] tens;
        logic [4:0] units;
        logic [7:0] type_c;
        logic [7:0] tens_c;
        logic [7:0] units_c;
        logic [7:0] sub_c;
        logic [7:0] b;
`ifdef STATUS_CHECKSUM_EN
        logic [7:0] csum;
`endif
        node    = f[6:2];
        tens    = (node >= 5'd30) ? 5'd3 : (node >= 5'd20) ? 5'd2 : (node >= 5'd10) ? 5'd1 : 5'd0;
        units   = node - tens * 5'd10;
        type_c  = type_char(f[8:7]);
        tens_c  = 8'h30 + {3'b000, tens};
        units_c = 8'h30 + {3'b000, units};
        sub_c   = 8'h30 + {6'b000000, f[1:0]};
`ifdef STATUS_CHECKSUM_EN
        csum    = type_c ^ 8'h2D ^ tens_c ^ units_c ^ 8'h2D ^ sub_c;
`endif
        case (idx)
            4'd0:    b = 8'h23;
            4'd1:    b = type_c;
            4'd2:    b = 8'h2D;
            4'd3:    b = tens_c;
            4'd4:    b = units_c;
            4'd5:    b = 8'h2D;
            4'd6:    b = sub_c;
`ifdef STATUS_CHECKSUM_EN
            4'd7:    b = hex_char(csum[7:4]);
            4'd8:    b = hex_char(csum[3:0]);
            4'd9:    b = 8'h23;
            4'd10:   b = 8'h0A;
`else
            4'd7:    b = 8'h23;
            4'd8:    b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign evt_ready   = (count_q != 3'd4);
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q != IDLE) || (count_q != 3'd0);
    assign frame_count = frame_count_q;

    // FIFO bookkeeping and frame sequencing; outputs are registered so the
    // byte for the next state is computed here one cycle ahead.
    always_comb begin
        state_d       = state_q;
        fifo_mem_d    = fifo_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        frame_d       = frame_q;
        idx_d         = idx_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        frame_count_d = frame_count_q;

        push = evt_valid && evt_ready;
        pop  = (state_q == LOAD);

        if (push) begin
            fifo_mem_d[wr_ptr_q] = {evt_type, evt_node, evt_subunit};
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (!push && pop) begin
            count_d = count_q - 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (count_q != 3'd0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                frame_d    = fifo_mem_q[rd_ptr_q];
                idx_d      = 4'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = frame_byte(fifo_mem_q[rd_ptr_q], 4'd0);
                state_d    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d       = IDLE;
                        tx_valid_d    = 1'b0;
                        tx_data_d     = 8'h00;
                        frame_count_d = frame_count_q + 8'd1;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = frame_byte(frame_q, idx_q + 4'd1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 9'd0;
            end
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            count_q       <= 3'd0;
            frame_q       <= 9'd0;
            idx_q         <= 4'd0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            fifo_mem_q    <= fifo_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_q       <= frame_d;
            idx_q         <= idx_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_status_message_encoder.sv
// Directed self-checking bench for status_message_encoder; honours STATUS_CHECKSUM_EN
// so the expected frames match the build.
module tb_status_message_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_type;
    logic [4:0] evt_node;
    logic [1:0] evt_subunit;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [7:0] frame_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    status_message_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_type    (evt_type),
        .evt_node    (evt_node),
        .evt_subunit (evt_subunit),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        evt_valid = 1'b0;
        tx_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic offer_event(input int t, input int n, input int s);
        evt_type    = 2'(t);
        evt_node    = 5'(n);
        evt_subunit = 2'(s);
        evt_valid   = 1'b1;
        step();
        evt_valid = 1'b0;
    endtask

    function automatic string exp_frame(input int t, input int n, input int s);
        string tchars = "NPDE";
        string f;
`ifdef STATUS_CHECKSUM_EN
        logic [7:0] x;
`endif
        f = $sformatf("#%c-%02d-%0d", tchars[t], n, s);
`ifdef STATUS_CHECKSUM_EN
        x = 8'h00;
        for (int i = 1; i < f.len(); i++) x = x ^ f[i];
        f = {f, $sformatf("%02X", x)};
`endif
        return {f, "#\n"};
    endfunction

    task automatic test_reset();
        rst = 1'b1; evt_valid = 1'b0; tx_ready = 1'b0;
        evt_type = 2'd0; evt_node = 5'd0; evt_subunit = 2'd0;
        step();
        n_compared++;
        if (evt_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_evt_ready: got %b want 1", evt_ready); end
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_compared++;
        if (tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_compared++;
        if (frame_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_frame_count: got %0d want 0", frame_count); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        string      exp;
        logic [7:0] e;
`ifdef STATUS_CHECKSUM_EN
        exp = "#P-07-265#\n";
`else
        exp = "#P-07-2#\n";
`endif
        tx_ready = 1'b1;
        evt_type = 2'd1; evt_node = 5'd7; evt_subunit = 2'd2;
        n_compared++;
        if (evt_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_ready: got %b want 1", evt_ready); end
        evt_valid = 1'b1;
        step();
        evt_valid = 1'b0;
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_idle_valid: got %b want 0", tx_valid); end
        step();
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_load_valid: got %b want 0", tx_valid); end
        step();
        for (int i = 0; i < exp.len(); i++) begin
            e = exp[i];
            n_compared++;
            if ({tx_valid, tx_data} !== {1'b1, e}) begin
                n_mismatched++;
                $display("[TB] FAIL single_byte%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, e);
            end
            step();
        end
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_end_valid: got %b want 0", tx_valid); end
        n_compared++;
        if (frame_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL single_frame_count: got %0d want 1", frame_count); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_encoding();
        string      exp_tab [3];
        int         t_tab [3] = '{0, 2, 1};
        int         n_tab [3] = '{5, 0, 19};
        int         s_tab [3] = '{1, 3, 0};
        logic [7:0] rxq [$];
        logic [7:0] e;
        logic [7:0] fc0;
        int         cyc;
`ifdef STATUS_CHECKSUM_EN
        // 0x4E^0x2D^0x30^0x35^0x2D^0x31 = 0x7A
        exp_tab = '{"#N-05-17A#\n", "#D-00-377#\n", "#P-19-068#\n"};
`else
        exp_tab = '{"#N-05-1#\n", "#D-00-3#\n", "#P-19-0#\n"};
`endif
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rxq.delete();
            fc0 = frame_count;
            offer_event(t_tab[k], n_tab[k], s_tab[k]);
            cyc = 0;
            while (frame_count == fc0 && cyc < 60) begin
                if (tx_valid && tx_ready) rxq.push_back(tx_data);
                step();
                cyc++;
            end
            n_compared++;
            if (rxq.size() !== exp_tab[k].len()) begin
                n_mismatched++;
                $display("[TB] FAIL encode%0d_len: got %0d want %0d", k, rxq.size(), exp_tab[k].len());
            end else begin
                for (int i = 0; i < rxq.size(); i++) begin
                    e = exp_tab[k][i];
                    n_compared++;
                    if (rxq[i] !== e) begin
                        n_mismatched++;
                        $display("[TB] FAIL encode%0d_byte%0d: got %h want %h", k, i, rxq[i], e);
                    end
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        int         ev_t [6] = '{0, 1, 2, 3, 0, 1};
        int         ev_n [6] = '{1, 3, 10, 22, 31, 9};
        int         ev_s [6] = '{0, 1, 2, 3, 0, 2};
        logic [7:0] expq [$];
        logic [7:0] rxq [$];
        string      f;
        logic       exp_rdy;
        logic       accepted;
        logic [7:0] frames_at_accept;
        logic       had_byte;
        int         gap;
        int         min_gap;
        int         cyc;
        do_reset();
        tx_ready = 1'b0;
        offer_event(ev_t[0], ev_n[0], ev_s[0]);
        step();
        step();
        n_compared++;
        if (tx_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fifo_stalled_valid: got %b want 1", tx_valid); end
        for (int i = 1; i < 6; i++) begin
            evt_type = 2'(ev_t[i]); evt_node = 5'(ev_n[i]); evt_subunit = 2'(ev_s[i]);
            evt_valid = 1'b1;
            exp_rdy = (i < 5);
            n_compared++;
            if (evt_ready !== exp_rdy) begin
                n_mismatched++;
                $display("[TB] FAIL fifo_ready_evt%0d: got %b want %b", i, evt_ready, exp_rdy);
            end
            if (i < 5) step();
        end
        tx_ready = 1'b1;
        accepted = 1'b0; frames_at_accept = 8'hFF;
        had_byte = 1'b0; gap = 0; min_gap = 99; cyc = 0;
        while (cyc < 400 && !(accepted && !busy)) begin
            if (evt_valid && evt_ready) begin
                accepted = 1'b1;
                frames_at_accept = frame_count;
            end
            if (tx_valid) begin
                if (had_byte && gap > 0 && gap < min_gap) min_gap = gap;
                gap = 0;
                had_byte = 1'b1;
                rxq.push_back(tx_data);
            end else if (had_byte) begin
                gap++;
            end
            step();
            if (accepted) evt_valid = 1'b0;
            cyc++;
        end
        evt_valid = 1'b0;
        n_compared++;
        if (accepted !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fifo_fifth_accepted: got %b want 1", accepted); end
        n_compared++;
        if (frames_at_accept !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL fifo_fifth_timing: got frames=%0d want 1", frames_at_accept);
        end
        n_compared++;
        if (min_gap !== 2) begin n_mismatched++; $display("[TB] FAIL fifo_frame_gap: got %0d want 2", min_gap); end
        for (int k = 0; k < 6; k++) begin
            f = exp_frame(ev_t[k], ev_n[k], ev_s[k]);
            for (int j = 0; j < f.len(); j++) expq.push_back(f[j]);
        end
        n_compared++;
        if (rxq.size() !== expq.size()) begin
            n_mismatched++;
            $display("[TB] FAIL fifo_stream_len: got %0d want %0d", rxq.size(), expq.size());
        end else begin
            for (int i = 0; i < rxq.size(); i++) begin
                n_compared++;
                if (rxq[i] !== expq[i]) begin
                    n_mismatched++;
                    $display("[TB] FAIL fifo_stream_byte%0d: got %h want %h", i, rxq[i], expq[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        string      exp;
        logic [7:0] rxq [$];
        logic [7:0] e;
        logic       prev_stall;
        logic [7:0] prev_data;
        int         cyc;
`ifdef STATUS_CHECKSUM_EN
        exp = "#E-31-077#\n";
`else
        exp = "#E-31-0#\n";
`endif
        tx_ready = 1'b0;
        offer_event(3, 31, 0);
        prev_stall = 1'b0; prev_data = 8'h00; cyc = 0;
        while (rxq.size() < exp.len() && cyc < 500) begin
            if (tx_valid && prev_stall) begin
                n_compared++;
                if (tx_data !== prev_data) begin
                    n_mismatched++;
                    $display("[TB] FAIL stall_hold_cycle%0d: got %h want %h", cyc, tx_data, prev_data);
                end
            end
            tx_ready = 1'($urandom_range(0, 1));
            if (tx_valid && tx_ready) rxq.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            step();
            cyc++;
        end
        tx_ready = 1'b1;
        n_compared++;
        if (rxq.size() !== exp.len()) begin
            n_mismatched++;
            $display("[TB] FAIL stall_len: got %0d want %0d", rxq.size(), exp.len());
        end else begin
            for (int i = 0; i < rxq.size(); i++) begin
                e = exp[i];
                n_compared++;
                if (rxq[i] !== e) begin
                    n_mismatched++;
                    $display("[TB] FAIL stall_byte%0d: got %h want %h", i, rxq[i], e);
                end
            end
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_frame();
        string      exp;
        logic [7:0] rxq [$];
        logic [7:0] e;
        logic       seen_valid;
        int         hs;
        int         cyc;
        tx_ready = 1'b1;
        offer_event(1, 4, 1);
        offer_event(2, 5, 2);
        offer_event(3, 6, 3);
        hs = 0; cyc = 0;
        while (hs < 4 && cyc < 40) begin
            if (tx_valid && tx_ready) hs++;
            step();
            cyc++;
        end
        n_compared++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h34}) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_at_idx4: got valid=%b data=%h want valid=1 data=34", tx_valid, tx_data);
        end
        rst = 1'b1;
        #1;
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_tx_valid: got %b want 0", tx_valid); end
        n_compared++;
        if (tx_data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL midreset_tx_data: got %h want 00", tx_data); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
        n_compared++;
        if (frame_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL midreset_frame_count: got %0d want 0", frame_count); end
        n_compared++;
        if (evt_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_evt_ready: got %b want 1", evt_ready); end
        step();
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid) seen_valid = 1'b1;
            step();
        end
        n_compared++;
        if (seen_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_quiet: got valid seen=%b want 0", seen_valid); end
        exp = exp_frame(0, 2, 3);
        offer_event(0, 2, 3);
        cyc = 0;
        while (frame_count == 8'd0 && cyc < 60) begin
            if (tx_valid && tx_ready) rxq.push_back(tx_data);
            step();
            cyc++;
        end
        n_compared++;
        if (frame_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL midreset_new_count: got %0d want 1", frame_count); end
        n_compared++;
        if (rxq.size() !== exp.len()) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_new_len: got %0d want %0d", rxq.size(), exp.len());
        end else begin
            for (int i = 0; i < rxq.size(); i++) begin
                e = exp[i];
                n_compared++;
                if (rxq[i] !== e) begin
                    n_mismatched++;
                    $display("[TB] FAIL midreset_new_byte%0d: got %h want %h", i, rxq[i], e);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int cyc;
        do_reset();
        tx_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            offer_event(f % 4, f % 32, f % 4);
            cyc = 0;
            while (frame_count !== 8'(f + 1) && cyc < 40) begin
                step();
                cyc++;
            end
            if (cyc >= 40) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL wrap_timeout_frame%0d: got count=%0d want %0d", f, frame_count, 8'(f + 1));
                break;
            end
            if (f == 254) begin
                n_compared++;
                if (frame_count !== 8'd255) begin n_mismatched++; $display("[TB] FAIL wrap_at_255: got %0d want 255", frame_count); end
            end
        end
        n_compared++;
        if (frame_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL wrap_to_zero: got %0d want 0", frame_count); end
    endtask

    initial begin
        rst = 1'b1; evt_valid = 1'b0; tx_ready = 1'b0;
        evt_type = 2'd0; evt_node = 5'd0; evt_subunit = 2'd0;
        test_reset();
        test_single_frame();
        test_encoding();
        test_fifo_full();
        test_stall();
        test_reset_mid_frame();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
